// File: rtl/cw305_trigger_ctrl_pkg.sv
// Shared definitions for the CW305 crypto launch/trigger controller:
// trigger mode codes, FSM state encoding and the saturating counter helper.
package cw305_trig_pkg;

   localparam logic [1:0] MODE_FOLLOW = 2'd0;
   localparam logic [1:0] MODE_PULSE  = 2'd1;
   localparam logic [1:0] MODE_WINDOW = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam int unsigned SAT_W = 32;

   // Increment that sticks at max_v instead of wrapping.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                input logic [SAT_W-1:0] max_v);
      return (v >= max_v) ? max_v : v + SAT_W'(1);
   endfunction

endpackage

// File: rtl/cw305_trigger_ctrl_if.sv
// Register-block / crypto-core side bundle of the trigger controller.
// master = register block and cores, slave = the controller.
interface cw305_trigger_ctrl_if #(
   parameter int unsigned pCHANNELS  = 2,
   parameter int unsigned pSEL_WIDTH = 4,
   parameter int unsigned pCNT_WIDTH = 16,
   parameter int unsigned pPW_WIDTH  = 8
);
   logic                  I_start;
   logic [pSEL_WIDTH-1:0] I_sel;
   logic [1:0]            I_mode;
   logic [pCNT_WIDTH-1:0] I_delay;
   logic [pPW_WIDTH-1:0]  I_width;
   logic [pCNT_WIDTH-1:0] I_timeout;
   logic [pCHANNELS-1:0]  I_busy;
   logic [pCHANNELS-1:0]  O_load;
   logic                  O_trigger;
   logic                  O_busy;
   logic                  O_done;
   logic                  O_timeout;
   logic [pCNT_WIDTH-1:0] O_cycles;

   modport master (
      output I_start, I_sel, I_mode, I_delay, I_width, I_timeout, I_busy,
      input  O_load, O_trigger, O_busy, O_done, O_timeout, O_cycles
   );

   modport slave (
      input  I_start, I_sel, I_mode, I_delay, I_width, I_timeout, I_busy,
      output O_load, O_trigger, O_busy, O_done, O_timeout, O_cycles
   );
endinterface

// File: rtl/cw305_trig_gen.sv
// Trigger generator: evaluates the trigger for the upcoming cycle from the
// controller's next-state values and registers it onto tio_trigger.
module cw305_trig_gen
   import cw305_trig_pkg::*;
#(
   parameter int unsigned pCNT_WIDTH = 16,
   parameter int unsigned pPW_WIDTH  = 8
) (
   input  logic                  crypto_clk,
   input  logic                  reset_i,
   input  logic [1:0]            mode,
   input  logic [pCNT_WIDTH-1:0] cnt,
   input  logic [pCNT_WIDTH-1:0] delay,
   input  logic [pPW_WIDTH-1:0]  width,
   input  logic                  busy,
   input  state_t                state,
   output logic                  trigger
);

   logic [pCNT_WIDTH:0] pulse_end;
   logic                in_run;
   logic                active;
   logic                past_delay;
   logic                in_pulse;
   logic                trig_d;

   // pulse_end carries one extra bit so delay + width cannot overflow
   assign pulse_end  = (pCNT_WIDTH+1)'(delay) + (pCNT_WIDTH+1)'(width);
   assign in_run     = (state == ST_WAIT_BUSY) || (state == ST_RUN);
   assign active     = in_run || (state == ST_LOAD);
   assign past_delay = (cnt >= delay);
   assign in_pulse   = ((pCNT_WIDTH+1)'(cnt) < pulse_end);

   always_comb begin
      trig_d = 1'b0;
      case (mode)
         MODE_PULSE:  trig_d = active && past_delay && in_pulse;
         MODE_WINDOW: trig_d = active && past_delay;
         default:     trig_d = in_run && busy;
      endcase
   end

   always_ff @(posedge crypto_clk or posedge reset_i) begin
      if (reset_i) trigger <= 1'b0;
      else         trigger <= trig_d;
   end

endmodule

// File: rtl/cw305_trigger_ctrl.sv
// Launch controller for pCHANNELS crypto cores: load pulse, busy tracking,
// cycle counter, watchdog and sticky done/timeout status.
module cw305_trigger_ctrl
   import cw305_trig_pkg::*;
#(
   parameter int unsigned pCHANNELS  = 2,
   parameter int unsigned pSEL_WIDTH = 4,
   parameter int unsigned pCNT_WIDTH = 16,
   parameter int unsigned pPW_WIDTH  = 8
) (
   input  logic                crypto_clk,
   input  logic                reset_i,
   cw305_trigger_ctrl_if.slave bus
);

   localparam int unsigned EXT_W = 1 << pSEL_WIDTH;
   localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                state_q, state_d;
   logic [pSEL_WIDTH-1:0] sel_q, sel_d;
   logic [1:0]            mode_q, mode_d;
   logic [pCNT_WIDTH-1:0] delay_q, delay_d;
   logic [pPW_WIDTH-1:0]  width_q, width_d;
   logic [pCNT_WIDTH-1:0] timeout_q, timeout_d;
   logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [pCHANNELS-1:0]  load_q, load_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tmo_q, tmo_d;

   logic [EXT_W-1:0]      busy_ext;
   logic [EXT_W-1:0]      load_ext;
   logic                  busy_sel;
   logic                  start_ok;
   logic                  wd_hit;
   logic [pCNT_WIDTH-1:0] cnt_inc;

   // busy/load are widened to the full select range so any sel indexes safely
   assign busy_ext = EXT_W'(bus.I_busy);
   assign busy_sel = busy_ext[sel_q];
   assign load_ext = EXT_W'(1) << bus.I_sel;
   assign start_ok = bus.I_start && (32'(bus.I_sel) < pCHANNELS) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign wd_hit   = (timeout_q != '0) && (cnt_q == timeout_q);
   assign cnt_inc  = pCNT_WIDTH'(sat_inc(SAT_W'(cnt_q), SAT_W'(CNT_MAX)));

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      mode_d    = mode_q;
      delay_d   = delay_q;
      width_d   = width_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;
      load_d    = '0;
      busy_d    = busy_q;
      done_d    = done_q;
      tmo_d     = tmo_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d   = ST_LOAD;
               sel_d     = bus.I_sel;
               mode_d    = bus.I_mode;
               delay_d   = bus.I_delay;
               width_d   = bus.I_width;
               timeout_d = bus.I_timeout;
               cnt_d     = '0;
               load_d    = pCHANNELS'(load_ext);
               busy_d    = 1'b1;
               done_d    = 1'b0;
               tmo_d     = 1'b0;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT_BUSY;
            cnt_d   = cnt_inc;
         end
         ST_WAIT_BUSY: begin
            if (wd_hit) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               if (busy_sel) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // a core finishing on the watchdog cycle counts as a normal end
            if (!busy_sel) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (wd_hit) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge crypto_clk or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         mode_q    <= '0;
         delay_q   <= '0;
         width_q   <= '0;
         timeout_q <= '0;
         cnt_q     <= '0;
         load_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         mode_q    <= mode_d;
         delay_q   <= delay_d;
         width_q   <= width_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tmo_q     <= tmo_d;
      end
   end

   cw305_trig_gen #(
      .pCNT_WIDTH (pCNT_WIDTH),
      .pPW_WIDTH  (pPW_WIDTH)
   ) u_trig_gen (
      .crypto_clk (crypto_clk),
      .reset_i    (reset_i),
      .mode       (mode_d),
      .cnt        (cnt_d),
      .delay      (delay_d),
      .width      (width_d),
      .busy       (busy_sel),
      .state      (state_d),
      .trigger    (bus.O_trigger)
   );

   assign bus.O_load    = load_q;
   assign bus.O_busy    = busy_q;
   assign bus.O_done    = done_q;
   assign bus.O_timeout = tmo_q;
   assign bus.O_cycles  = cnt_q;

endmodule

// File: doc/cw305_trigger_ctrl.md
Name: cw305_trigger_ctrl

Overview:
Parametrised crypto-core launch and trigger controller for the CW305 target. It generalises the single-core load/busy/trigger hookup to pCHANNELS selectable cores, and sits between the register block (start, settings) and the crypto cores (load, busy) in the crypto clock domain. It adds programmable trigger modes (follow, delayed pulse, window), a per-operation cycle counter and a watchdog timeout, with sticky done and timeout status that the register block reads back.

Parameters:
pCHANNELS, 2, number of attached crypto cores (1..16)
pSEL_WIDTH, 4, width of the channel-select field
pCNT_WIDTH, 16, width of the cycle counter, timeout and delay fields
pPW_WIDTH, 8, width of the pulse-width field

Ports:
crypto_clk  in  1  crypto clock; the only clock
reset_i  in  1  asynchronous, active-high reset
I_start  in  1  single-cycle start request from the register block
I_sel  in  pSEL_WIDTH  core select
I_mode  in  2  trigger mode: 0 FOLLOW, 1 PULSE, 2 WINDOW, 3 treated as FOLLOW
I_delay  in  pCNT_WIDTH  trigger delay in cycles after load
I_width  in  pPW_WIDTH  pulse width in cycles (PULSE mode only)
I_timeout  in  pCNT_WIDTH  watchdog limit in cycles; 0 disables the watchdog
I_busy  in  pCHANNELS  per-core busy
O_load  out  pCHANNELS  one-hot, single-cycle load to the selected core
O_trigger  out  1  trigger to tio_trigger
O_busy  out  1  high while an operation is in flight
O_done  out  1  sticky; high from operation end until the next accepted start
O_timeout  out  1  sticky; high if the last operation ended by watchdog
O_cycles  out  pCNT_WIDTH  measured operation length, saturating

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Reset is asynchronous, so an operation in flight is abandoned immediately and no load or trigger glitch follows the release of reset.
- States: IDLE, LOAD, WAIT_BUSY, RUN, DONE. All outputs are registered.
- Start acceptance:
  - I_start is accepted only in IDLE or DONE, and only if I_sel < pCHANNELS.
  - Otherwise I_start is ignored, with no state change and no status change.
- Sampling: on acceptance, I_sel, I_mode, I_delay, I_width and I_timeout are latched. Later changes to these inputs do not affect the operation in flight.
- Start cycle: the start is sampled at cycle S. The next state is LOAD, and O_done and O_timeout clear at S+1.
- LOAD (cycle L = S+1):
  - O_load[sel] = 1 for exactly one cycle; all other bits stay 0.
  - O_busy = 1, and the counter is 0.
  - The next state is WAIT_BUSY.
- Counter:
  - O_cycles = k at cycle L+k.
  - It saturates at all-ones and never wraps.
  - It freezes on entering DONE and holds until the next accepted start.
- WAIT_BUSY: when busy[sel] is sampled high, the next state is RUN.
- RUN:
  - The first cycle in which busy[sel] is sampled low ends the operation, and the next state is DONE.
  - O_cycles holds the count of that sample cycle.
- Watchdog:
  - Active only when I_timeout != 0, in WAIT_BUSY or RUN.
  - When the counter equals the latched timeout, the next state is DONE with O_timeout = 1.
  - With the watchdog disabled and busy never rising, the block stays in WAIT_BUSY until reset. This is intended.
- DONE:
  - O_done = 1 and O_busy = 0.
  - A valid start moves to LOAD. A start in the same cycle the operation ends, or while the block is busy, is dropped.
- Trigger in FOLLOW mode:
  - O_trigger = busy[sel] delayed by one cycle, gated to the WAIT_BUSY and RUN states.
  - I_delay is ignored.
- Trigger in PULSE mode:
  - O_trigger is high for counter values in [delay, delay + width).
  - width = 0 gives no pulse.
  - The pulse is truncated when the block enters DONE.
- Trigger in WINDOW mode: O_trigger is high from counter value = delay until the block enters DONE. It is low in DONE.
- Comparisons are unsigned. delay + width is computed at pCNT_WIDTH + 1 bits, so no overflow occurs.
- O_trigger is 0 in IDLE, LOAD-when-delay≠0 and DONE. With delay = 0 in PULSE or WINDOW mode, the trigger rises in cycle L.

Decomposition:
- Shared package cw305_trig_pkg holds:
  - the mode constants (MODE_FOLLOW, MODE_PULSE, MODE_WINDOW);
  - the state encoding;
  - the saturating-increment helper function.
- One sub-module, cw305_trig_gen, takes mode, counter, delay, width, busy and state, and produces the registered O_trigger. The top-level FSM, counter and watchdog stay in cw305_trigger_ctrl.

Test Plan:
1. FOLLOW, sel=1, busy[1] high for cycles L+1..L+10 -> O_load = 2'b10 at L only; O_trigger high L+2..L+11; O_done at L+12; O_cycles = 11; O_timeout = 0.
2. PULSE, delay=3, width=4, busy high for 20 cycles -> O_trigger high exactly at L+3..L+6; O_cycles = 21.
3. WINDOW, delay=5, busy high L+1..L+8 -> O_trigger high L+5..L+9, low from DONE onward.
4. Watchdog: timeout=8, busy never rises -> DONE with O_timeout = 1 at L+9 and O_cycles = 8. A new start clears O_done and O_timeout one cycle later.
5. Rejected starts: start while RUN, and start with sel = pCHANNELS -> no O_load pulse, state and O_cycles unchanged.
6. Asynchronous reset asserted mid-RUN with PULSE active -> O_trigger, O_busy, O_load and O_done go to 0 immediately; after reset release the block is in IDLE with no spurious load.
